imem_byte_loader: RTL and testbench

//   Write-side loader for the byte-addressed instruction memory. Receives a byte stream
//   (4-byte length header, payload, 1-byte XOR checksum) over a valid/ready handshake.

---
 rtl/imem_byte_loader_pkg.sv | 16 +
 rtl/imem_byte_loader.sv | 108 ++++++++++
 tb/tb_imem_byte_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_byte_loader_pkg.sv
// Shared definitions for the instruction-memory byte loader
// and the host-side stream driver.
package imem_byte_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } load_state_t;

    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/imem_byte_loader.sv
// Streams a length-prefixed, XOR-checksummed image into
// the instruction memory while holding the CPU.
module imem_byte_loader
    import imem_byte_loader_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    load_state_t       state;
    load_state_t       state_n;
    logic [31:0]       len;
    logic [31:0]       len_full;
    logic [1:0]        hcnt;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        csum;
    logic              fire;
    logic              hdr_last;
    logic              pay_last;
    logic              start_ok;

    assign in_ready = (state == HDR) || (state == PAY) || (state == CHK);
    assign fire     = in_valid && in_ready;
    // Header is little-endian: each new byte shifts in at the top.
    assign len_full = {in_data, len[31:8]};
    assign hdr_last = (hcnt == 2'(HDR_BYTES - 1));
    assign pay_last = (32'(cnt) == (len - 32'd1));
    assign start_ok = start &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_n = HDR;
            end
            HDR: begin
                if (fire && hdr_last) begin
                    if (len_full > 32'(MEM_SIZE)) state_n = ERR;
                    else if (len_full == 32'd0)   state_n = CHK;
                    else                          state_n = PAY;
                end
            end
            PAY: begin
                if (fire && pay_last) state_n = CHK;
            end
            CHK: begin
                if (fire) state_n = (in_data == csum) ? DONE : ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len       <= '0;
            hcnt      <= '0;
            cnt       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state    <= state_n;
            mem_we   <= 1'b0;
            // A corrupt image keeps the core held until the next load.
            cpu_hold <= (state_n == HDR) || (state_n == PAY) ||
                        (state_n == CHK) || (state_n == ERR);
            done     <= (state_n == DONE);
            error    <= (state_n == ERR);
            if (start_ok) begin
                len  <= '0;
                hcnt <= '0;
                cnt  <= '0;
                csum <= '0;
            end
            if (fire && (state == HDR)) begin
                len  <= len_full;
                hcnt <= hcnt + 2'd1;
            end
            if (fire && (state == PAY)) begin
                mem_we    <= 1'b1;
                mem_addr  <= cnt;
                mem_wdata <= in_data;
                cnt       <= cnt + 1'b1;
                csum      <= csum ^ in_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Self-checking bench for imem_byte_loader: vector table,
// hand-written corner sequences and randomized images.
module tb_imem_byte_loader;

    localparam int MEM = 1024;

    typedef struct {
        int          len;
        logic [7:0]  seed;
        logic [7:0]  flip;
        int          gap;
        logic        exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  pay [MEM];
    logic [39:0] wq [$];

    imem_byte_loader #(.MEM_SIZE(MEM), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x ^= pay[i];
        return x;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                chk("handshake timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
    endtask

    task automatic pick_gap(input int g, output int r);
        r = (g < 0) ? int'($urandom_range(0, 2)) : g;
    endtask

    task automatic send_image(input logic [31:0] len, input int npay,
                              input logic [7:0] cs, input int g);
        int gg;
        wq.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] l = len;
            send_byte(l[8*i +: 8], 0);
        end
        if (len <= 32'(MEM)) begin
            for (int i = 0; i < npay; i++) begin
                pick_gap(g, gg);
                send_byte(pay[i], gg);
            end
            pick_gap(g, gg);
            send_byte(cs, gg);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string nm, input int expw,
                                input logic ok);
        int bad = 0;
        repeat (3) @(negedge clk);
        chk({nm, " nwrites"}, 32'(wq.size()), 32'(expw));
        foreach (wq[i]) begin
            if (wq[i] !== {32'(i), pay[i]}) bad++;
        end
        chk({nm, " writes"}, 32'(bad), 32'd0);
        chk({nm, " done"}, 32'(done), 32'(ok));
        chk({nm, " error"}, 32'(error), 32'(!ok));
        chk({nm, " cpu_hold"}, 32'(cpu_hold), 32'(!ok));
        chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic run_ref(input string nm, input int len,
                           input logic [7:0] flip, input int g);
        logic [7:0] cs = ref_xor(len) ^ flip;
        logic       ok = (len <= MEM) && (flip == 8'h00);
        send_image(32'(len), len, cs, g);
        check_result(nm, (len <= MEM) ? len : 0, ok);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8,    8'h11, 8'h00, 1, 1'b1};
        vecs[1] = '{1,    8'h5A, 8'h00, 0, 1'b1};
        vecs[2] = '{3,    8'h01, 8'h80, 0, 1'b0};
        vecs[3] = '{0,    8'h00, 8'h00, 0, 1'b1};
        vecs[4] = '{1025, 8'h00, 8'h00, 0, 1'b0};
        vecs[5] = '{16,   8'hC3, 8'h00, 2, 1'b1};
        vecs[6] = '{2,    8'h77, 8'h01, 1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset outputs",
            {in_ready, mem_we, cpu_hold, done, error, mem_addr[7:0],
             mem_wdata}, '0);
        reset_n = 1'b1;

        // Hand sequence: the basic 4-byte image.
        pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
        wq.delete();
        @(negedge clk);
        start = 1'b1;
        chk("no ready at start", 32'(in_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("ready after start", 32'(in_ready), 32'd1);
        chk("hold after start", 32'(cpu_hold), 32'd1);
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(pay[i], 0);
        send_byte(8'h13, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("basic4", 4, 1'b1);

        // Corrupt checksum, then a good image clears the error.
        pay[0] = 8'hAA; pay[1] = 8'h55;
        send_image(32'd2, 2, 8'h00, 0);
        check_result("badcsum", 2, 1'b0);
        for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
        send_image(32'd4, 4, 8'h04, 0);
        check_result("recover", 4, 1'b1);

        foreach (vecs[v]) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            for (int i = 0; i < MEM; i++)
                pay[i] = vecs[v].seed + 8'(i * 29);
            run_ref(nm, vecs[v].len, vecs[v].flip, vecs[v].gap);
            chk({nm, " table done"}, 32'(done), 32'(vecs[v].exp_done));
        end

        // Bytes offered after an error must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("err no writes", 32'(wq.size()), 32'd2);
        chk("err sticky", 32'(error), 32'd1);

        // Full-size image reaches the top address.
        for (int i = 0; i < MEM; i++) pay[i] = 8'($urandom);
        run_ref("full", MEM, 8'h00, 0);
        chk("full last addr", (wq.size() > 0) ? wq[$][39:8] : 32'hFFFF_FFFF,
            32'h3FF);

        // Start in the middle of a load is ignored.
        for (int i = 0; i < 4; i++) pay[i] = 8'(8'h30 + i);
        wq.delete();
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(pay[0], 0); send_byte(pay[1], 0);
        @(negedge clk);
        in_valid = 1'b0;
        pulse_start();
        send_byte(pay[2], 0); send_byte(pay[3], 0);
        send_byte(ref_xor(4), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("midstart", 4, 1'b1);

        // Asynchronous reset in the middle of the payload.
        for (int i = 0; i < 8; i++) pay[i] = 8'(8'h90 + i);
        wq.delete();
        pulse_start();
        send_byte(8'h08, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_byte(pay[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold before reset", 32'(cpu_hold), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset outputs",
            {in_ready, mem_we, cpu_hold, done, error, mem_addr[7:0],
             mem_wdata}, '0);
        chk("writes before reset", 32'(wq.size()), 32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        run_ref("after reset", 5, 8'h00, 0);

        // Randomized images against the reference rules.
        for (int r = 0; r < 12; r++) begin
            int         len = int'($urandom_range(0, 24));
            logic [7:0] fl = ($urandom_range(0, 1) == 1) ?
                             8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            run_ref($sformatf("rand%0d", r), len, fl, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
